// File: rtl/dut_lane_arb_if.sv
// Lane arbiter bus: groups the requester-side signals of dut_lane_arb.
//   I_req  : per-requester request level
//   I_len  : packed burst lengths, requester r at [r*C_LEN_W +: C_LEN_W]
//   I_data : per-requester serial data bit
//   O_gnt  : one-hot grant, held for the whole burst
//   O_ack  : bit-consumed strobe per requester
//   O_done : one-cycle end-of-burst pulse per requester
//   O_lane : serialized lane bit (idle high)
//   O_busy : arbiter is sending or in the idle gap
// master = requester side, slave = arbiter side.
interface dut_lane_arb_if #(
    parameter int C_REQ_NUM = 4,
    parameter int C_LEN_W   = 8
);
    logic [C_REQ_NUM-1:0]         I_req;
    logic [C_REQ_NUM*C_LEN_W-1:0] I_len;
    logic [C_REQ_NUM-1:0]         I_data;
    logic [C_REQ_NUM-1:0]         O_gnt;
    logic [C_REQ_NUM-1:0]         O_ack;
    logic [C_REQ_NUM-1:0]         O_done;
    logic                         O_lane;
    logic                         O_busy;

    modport master (
        output I_req, I_len, I_data,
        input  O_gnt, O_ack, O_done, O_lane, O_busy
    );

    modport slave (
        input  I_req, I_len, I_data,
        output O_gnt, O_ack, O_done, O_lane, O_busy
    );
endinterface

// File: rtl/dut_lane_arb.sv
// Round-robin arbiter and burst sequencer for a single-bit serial lane.
// One requester is granted at a time; exactly its requested number of bits
// is streamed onto O_lane, followed by a fixed idle-high gap, then the next
// arbitration round starts from the requester after the last winner.
// Ports:
//   I_clk : clock, rising edge
//   I_rst : synchronous active-high reset
//   bus   : dut_lane_arb_if slave modport (requests, lengths, data in;
//           grant, ack, done, lane, busy out). All outputs are registered.
module dut_lane_arb #(
    parameter int C_REQ_NUM = 4,
    parameter int C_LEN_W   = 8,
    parameter int C_GAP     = 2
) (
    input  logic           I_clk,
    input  logic           I_rst,
    dut_lane_arb_if.slave  bus
);
    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int PW = $clog2(C_REQ_NUM);
    localparam int GW = $clog2(C_GAP + 1) + 1;

    logic [1:0]           r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_idx;
    logic [C_LEN_W-1:0]   r_len;
    logic [C_LEN_W:0]     r_cnt;
    logic [GW-1:0]        r_gcnt;
    logic [C_REQ_NUM-1:0] r_gnt;
    logic [C_REQ_NUM-1:0] r_ack;
    logic [C_REQ_NUM-1:0] r_done;
    logic                 r_lane;
    logic                 r_busy;

    logic [PW-1:0]        w_win;
    logic                 w_found;
    logic [PW-1:0]        w_ptr_nxt;
    logic [C_REQ_NUM-1:0] w_win_oh;
    logic [C_LEN_W-1:0]   w_len_win;
    logic [C_LEN_W:0]     w_cnt_nxt;
    logic                 w_last;

    // First set request at or after the pointer, wrapping around.
    always_comb begin
        int            j;
        logic [PW-1:0] w_j;
        w_win   = '0;
        w_found = 1'b0;
        j       = 0;
        w_j     = '0;
        for (int i = 0; i < C_REQ_NUM; i++) begin
            j = int'(r_ptr) + i;
            if (j >= C_REQ_NUM) begin
                j = j - C_REQ_NUM;
            end
            w_j = PW'(j);
            if (!w_found && bus.I_req[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
    end

    assign w_ptr_nxt = (w_win == PW'(C_REQ_NUM - 1)) ? '0 : w_win + 1'b1;
    assign w_win_oh  = {{(C_REQ_NUM-1){1'b0}}, 1'b1} << w_win;
    assign w_len_win = bus.I_len[int'(w_win)*C_LEN_W +: C_LEN_W];

    // A bit is consumed on every SEND edge where the registered ack is high.
    // The counter is one bit wider than the length so a full-scale length
    // still terminates instead of wrapping. A zero-length burst sees no ack
    // and finishes on its first SEND edge.
    assign w_cnt_nxt = r_cnt + {{C_LEN_W{1'b0}}, |r_ack};
    assign w_last    = (w_cnt_nxt >= {1'b0, r_len});

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_lane  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                // ARB: grant one requester and latch its length
                ST_ARB: begin
                    if (w_found) begin
                        r_idx   <= w_win;
                        r_len   <= w_len_win;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= '0;
                        r_gnt   <= w_win_oh;
                        r_ack   <= (w_len_win != '0) ? w_win_oh : '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                // SEND: sample the granted bit on each acked edge
                ST_SEND: begin
                    if (|r_ack) begin
                        r_lane <= bus.I_data[r_idx];
                    end
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_ack   <= '0;
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                        r_gcnt  <= '0;
                        r_state <= ST_GAP;
                    end
                end
                // GAP: first cycle still shows the last bit alongside
                // O_done, then C_GAP idle-high cycles before re-arbitrating
                ST_GAP: begin
                    r_lane <= 1'b1;
                    if (r_gcnt == GW'(C_GAP)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_ARB;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign bus.O_gnt  = r_gnt;
    assign bus.O_ack  = r_ack;
    assign bus.O_done = r_done;
    assign bus.O_lane = r_lane;
    assign bus.O_busy = r_busy;
endmodule

// File: tb/tb_dut_lane_arb.sv
module tb_dut_lane_arb;
    localparam int N   = 4;
    localparam int LW  = 8;
    localparam int GAP = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dut_lane_arb_if #(.C_REQ_NUM(N), .C_LEN_W(LW)) bus ();

    dut_lane_arb #(.C_REQ_NUM(N), .C_LEN_W(LW), .C_GAP(GAP)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // {2'b0, gnt, ack, done, lane, busy}; idle/reset value is 16'h0002
    function automatic logic [15:0] outs();
        return {2'b00, bus.O_gnt, bus.O_ack, bus.O_done, bus.O_lane, bus.O_busy};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the falling edge where the grant is first visible.
    task automatic run_burst(input int idx, input int len, input logic [255:0] bits);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        chk("gnt", 16'(bus.O_gnt), 16'(oh));
        chk("busy_send", 16'(bus.O_busy), 16'd1);
        if (len == 0) begin
            chk("zl_ack", 16'(bus.O_ack), 16'd0);
            chk("zl_lane", 16'(bus.O_lane), 16'd1);
            @(negedge clk);
        end
        for (int k = 0; k < len; k++) begin
            bus.I_data = {4{~bits[k]}};
            bus.I_data[idx[1:0]] = bits[k];
            chk("ack", 16'(bus.O_ack), 16'(oh));
            chk("gnt_hold", 16'(bus.O_gnt), 16'(oh));
            if (k > 0) chk("lane", 16'(bus.O_lane), 16'(bits[k-1]));
            @(negedge clk);
        end
        chk("done", 16'(bus.O_done), 16'(oh));
        chk("gnt_clr", 16'(bus.O_gnt), 16'd0);
        chk("ack_clr", 16'(bus.O_ack), 16'd0);
        if (len > 0) chk("tail_lane", 16'(bus.O_lane), 16'(bits[len-1]));
        else         chk("tail_lane", 16'(bus.O_lane), 16'd1);
        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            chk("gap", outs(), 16'h0003);
        end
    endtask

    // ARB cycle after a gap, then the falling edge where a grant would show.
    task automatic arb_cycle();
        @(negedge clk);
        chk("arb_idle", outs(), 16'h0002);
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] pat;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.I_req  = '0;
        bus.I_len  = '0;
        bus.I_data = '0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 20; i++) begin
            bus.I_req  = 4'($urandom);
            bus.I_data = 4'($urandom);
            bus.I_len  = 32'($urandom);
            @(negedge clk);
            chk("reset_hold", outs(), 16'h0002);
        end
        rst = 1'b0;
        bus.I_req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_reset", outs(), 16'h0002);
        end

        // Single burst: requester 0, 3 bits 1,0,1 (pointer 0 -> 1)
        bus.I_req = 4'b0001;
        bus.I_len = {8'd0, 8'd0, 8'd0, 8'd3};
        @(negedge clk);
        bus.I_req = 4'b0000;
        bus.I_len = {8'd0, 8'd0, 8'd0, 8'd1};
        pat = '0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        run_burst(0, 3, pat);
        @(negedge clk);
        chk("single_idle", outs(), 16'h0002);

        // Contention: 1010 with pointer 1 -> order 1,3,1,3
        bus.I_req = 4'b1010;
        bus.I_len = {8'd2, 8'd2, 8'd2, 8'd2};
        @(negedge clk);
        pat = '0; pat[0] = 1'b0; pat[1] = 1'b1;
        run_burst(1, 2, pat);
        arb_cycle();
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b0;
        run_burst(3, 2, pat);
        arb_cycle();
        pat = '0; pat[0] = 1'b1; pat[1] = 1'b1;
        run_burst(1, 2, pat);
        arb_cycle();
        bus.I_req = 4'b0000;
        pat = '0; pat[0] = 1'b0; pat[1] = 1'b0;
        run_burst(3, 2, pat);
        arb_cycle();
        chk("cont_no_regrant", outs(), 16'h0002);

        // Zero-length burst on requester 2 (pointer 0 -> 3)
        bus.I_req = 4'b0100;
        bus.I_len = {8'd9, 8'd0, 8'd9, 8'd9};
        @(negedge clk);
        bus.I_req = 4'b0000;
        run_burst(2, 0, '0);
        @(negedge clk);
        chk("zl_idle", outs(), 16'h0002);

        // Reset mid-burst: 10-bit burst on requester 0, reset after 4th ack
        bus.I_req  = 4'b0001;
        bus.I_len  = {8'd0, 8'd0, 8'd0, 8'd10};
        bus.I_data = 4'b1110;
        @(negedge clk);
        chk("rmb_gnt", 16'(bus.O_gnt), 16'h0001);
        chk("rmb_ack1", 16'(bus.O_ack), 16'h0001);
        bus.I_req = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("rmb_ack", 16'(bus.O_ack), 16'h0001);
            chk("rmb_lane", 16'(bus.O_lane), 16'd0);
        end
        @(negedge clk);
        chk("rmb_ack5", 16'(bus.O_ack), 16'h0001);
        rst = 1'b1;
        @(negedge clk);
        chk("rmb_reset_vals", outs(), 16'h0002);

        // Full load after reset: pointer back at 0 -> 0,1,2,3,0
        rst = 1'b0;
        bus.I_req = 4'b1111;
        bus.I_len = {8'd255, 8'd0, 8'd5, 8'd1};
        @(negedge clk);
        chk("rmb_no_done", 16'(bus.O_done), 16'd0);
        pat = '0; pat[0] = 1'b0;
        run_burst(0, 1, pat);
        arb_cycle();
        pat = '0; pat[4:0] = 5'b10110;
        run_burst(1, 5, pat);
        arb_cycle();
        run_burst(2, 0, '0);
        arb_cycle();
        for (int i = 0; i < 256; i++) pat[i] = 1'($urandom_range(0, 1));
        run_burst(3, 255, pat);
        arb_cycle();
        bus.I_req = 4'b0000;
        pat = '0; pat[0] = 1'b1;
        run_burst(0, 1, pat);
        arb_cycle();
        chk("final_idle", outs(), 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dut_lane_arb.md
# dut_lane_arb

Round-robin arbiter and burst sequencer that shares the single-bit serial input lane of `dut_top` between several requesters. Each requester asks for the lane with a bit count; the block grants one requester at a time, streams exactly that many bits from it onto the lane, inserts a fixed idle gap, then re-arbitrates. It sits directly in front of `dut_top`'s `I_data_in`, and all lane traffic goes through it.

## Interface
- `C_REQ_NUM`, default 4: number of requesters (2..8).
- `C_LEN_W`, default 8: width of each burst-length field.
- `C_GAP`, default 2: idle cycles inserted after every burst (≥1).
- `I_clk` input 1: single clock; all logic on its rising edge.
- `I_rst` input 1: reset, synchronous, active-high.
- `I_req` input C_REQ_NUM: per-requester lane request level.
- `I_len` input C_REQ_NUM*C_LEN_W: burst length per requester; requester r uses bits [r*C_LEN_W +: C_LEN_W].
- `I_data` input C_REQ_NUM: serial data bit per requester.
- `O_gnt` output C_REQ_NUM: one-hot grant, held for the whole burst.
- `O_ack` output C_REQ_NUM: bit-consumed strobe; the requester advances its bit on each cycle where this is high.
- `O_done` output C_REQ_NUM: one-cycle pulse after the last bit of a burst.
- `O_lane` output 1: serial bit to `dut_top` `I_data_in`; idle level is 1.
- `O_busy` output 1: high in SEND or GAP.

## Operation
- States: ARB, SEND, GAP. All outputs are registered.
- Reset: state=ARB, pointer=0, counter=0, O_gnt=0, O_ack=0, O_done=0, O_lane=1, O_busy=0.
- ARB:
  - If I_req=0, stay in ARB.
  - Otherwise select the first set request at or after the pointer, wrapping modulo C_REQ_NUM. Call it w.
  - Latch len=I_len[w], set O_gnt=onehot(w), set pointer=w+1 (wrapping), go to SEND.
- SEND:
  - Each cycle, while the counter is less than len:
    - O_ack[w]=1.
    - I_data[w] is sampled at that edge.
    - The sampled bit appears on O_lane on the next cycle.
    - The counter increments.
  - The cycle after the final ack: O_done[w]=1, O_gnt is cleared, go to GAP.
- Zero-length burst (len=0): SEND lasts one cycle with no ack, O_done[w] pulses, and O_lane stays 1.
- GAP: O_lane=1 for C_GAP cycles, then go to ARB. Requests are not evaluated during GAP.
- Request sampling: I_req and I_len are sampled only in ARB.
  - Deasserting I_req[w] mid-burst does not shorten the burst.
  - Changing I_len[w] mid-burst has no effect on the current burst.
- Counter width is C_LEN_W+1 so that len=2^C_LEN_W−1 terminates correctly with no wrap.
- Reset asserted mid-operation:
  - The burst is abandoned; no O_done is issued.
  - On the cycle after reset, all outputs hold their reset values.
  - The pointer returns to 0.

## Timing
- Request to grant: I_req seen high at edge t in ARB → O_gnt valid and first O_ack high from edge t+1.
- Data latency: the bit sampled with O_ack at edge k appears on O_lane from edge k+1 to k+2.
- A burst of length L (L≥1):
  - O_ack is high for L consecutive cycles.
  - O_done pulses on the cycle after the last O_ack.
  - O_lane carries the L bits on the L cycles after the first O_ack.
- Next grant, earliest: 1 cycle (SEND tail) + C_GAP cycles after the last ack, plus 1 ARB cycle.
- Simultaneous requests: only one grant per ARB visit. Under full load, service order is strictly pointer-rotated, so a persistent requester waits at most C_REQ_NUM−1 bursts.

## Test plan
- Reset: hold I_rst=1 for 20 cycles with random I_req/I_data → O_lane=1, O_gnt=O_ack=O_done=0, O_busy=0 throughout; release, I_req=0 → still idle.
- Single burst: I_req=4'b0001, I_len[0]=3, I_data[0] driven 1,0,1 on successive acks → O_gnt=0001, three O_ack[0] pulses, O_lane=1,0,1, O_done[0] one cycle later, then 2 idle-high cycles.
- Contention: I_req=4'b1010 held, all len=2 → grant order 1,3,1,3; each O_done matches the granted index; O_gnt is never multi-hot.
- Zero length: I_req=4'b0100, I_len[2]=0 → one SEND cycle with no O_ack, O_done[2] pulses, O_lane stays 1, GAP follows.
- Reset mid-burst: I_len[0]=10, assert I_rst after the 4th ack → next cycle all outputs at reset values, no O_done; after release, pointer=0 so requester 0 is granted first among 4'b1111.
- Full load fairness: I_req=4'b1111 with lengths 1,5,0,255 → grants cycle 0,1,2,3,0; the 255-bit burst yields exactly 255 acks with no counter wrap.
